// File: rtl/digest_serializer_pkg.sv
// Shared definitions for the digest serializer: default digest width,
// serializer state encoding and the nibble-to-ASCII helper.
// Ports: none (package only).
package sha_pkg;

    localparam int DIGEST_BITS_DEFAULT = 512;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Lowercase hex digit: 0-9 -> '0'-'9', a-f -> 'a'-'f'.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] chr;
        if (nib < 4'd10) begin
            chr = 8'h30 + {4'h0, nib};
        end else begin
            chr = 8'h57 + {4'h0, nib};
        end
        return chr;
    endfunction

endpackage

// File: rtl/digest_serializer_hex_nibble_enc.sv
// hex_nibble_enc: purely combinational 4-bit to lowercase ASCII encoder.
// Ports: nib_i  4-bit nibble in
//        chr_o  8-bit ASCII character out
module hex_nibble_enc
    import sha_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] chr_o
);

    assign chr_o = hex_char(nib_i);

endmodule

// File: rtl/digest_serializer.sv
// digest_serializer: captures a DIGEST_BITS digest in one cycle and streams it
// MSB-first as bytes over valid/ready. With DIGEST_SERIALIZER_HEX_EN defined,
// each byte leaves as two lowercase ASCII hex characters, high nibble first.
// Ports: clk, reset (sync, active-high)
//        digest / digest_valid / digest_ack  - capture side (ack pulses on capture)
//        busy                                - stream in progress
//        byte_out / byte_valid / byte_ready  - output stream
//        last                                - final byte/character marker
module digest_serializer
    import sha_pkg::*;
#(
    parameter int DIGEST_BITS = DIGEST_BITS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DIGEST_BITS-1:0] digest,
    input  logic                   digest_valid,
    output logic                   digest_ack,
    output logic                   busy,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   last
);

    localparam int NBYTES = DIGEST_BITS / 8;
`ifdef DIGEST_SERIALIZER_HEX_EN
    localparam int NXFER  = 2 * NBYTES;
`else
    localparam int NXFER  = NBYTES;
`endif
    // A one-byte raw digest still needs a 1-bit counter to exist.
    localparam int CNT_W  = (NXFER > 1) ? $clog2(NXFER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NXFER - 1);

    ser_state_t             state_q, state_d;
    logic [DIGEST_BITS-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             top_byte;
    logic                   sending;
    logic                   last_xfer;

    assign sending   = (state_q == SEND);
    assign top_byte  = sreg_q[DIGEST_BITS-1 -: 8];
    assign last_xfer = sending && (cnt_q == CNT_LAST);

    assign digest_ack = (state_q == IDLE) && digest_valid;
    assign busy       = sending;
    assign byte_valid = sending;
    assign last       = last_xfer;

`ifdef DIGEST_SERIALIZER_HEX_EN
    logic       phase_q, phase_d;
    logic [3:0] nib_sel;
    logic [7:0] hex_chr;

    // phase 0 shows the high nibble, phase 1 the low nibble.
    assign nib_sel = phase_q ? top_byte[3:0] : top_byte[7:4];

    hex_nibble_enc u_hex_enc (
        .nib_i (nib_sel),
        .chr_o (hex_chr)
    );

    assign byte_out = sending ? hex_chr : 8'h00;
`else
    assign byte_out = sending ? top_byte : 8'h00;
`endif

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
`ifdef DIGEST_SERIALIZER_HEX_EN
        phase_d = phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (digest_valid) begin
                    state_d = SEND;
                    sreg_d  = digest;
                    cnt_d   = '0;
`ifdef DIGEST_SERIALIZER_HEX_EN
                    phase_d = 1'b0;
`endif
                end
            end
            SEND: begin
                if (byte_ready) begin
                    if (last_xfer) begin
                        // Leave nothing of the old digest behind for the next capture.
                        state_d = IDLE;
                        sreg_d  = '0;
                        cnt_d   = '0;
`ifdef DIGEST_SERIALIZER_HEX_EN
                        phase_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
`ifdef DIGEST_SERIALIZER_HEX_EN
                        // Only advance to the next byte once its low nibble has gone.
                        if (phase_q) begin
                            sreg_d  = sreg_q << 8;
                            phase_d = 1'b0;
                        end else begin
                            phase_d = 1'b1;
                        end
`else
                        sreg_d = sreg_q << 8;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
`ifdef DIGEST_SERIALIZER_HEX_EN
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
`ifdef DIGEST_SERIALIZER_HEX_EN
            phase_q <= phase_d;
`endif
        end
    end

endmodule

// File: tb/tb_digest_serializer.sv
module tb_digest_serializer;

`ifdef DIGEST_SERIALIZER_HEX_EN
    localparam int HEXM = 2;
`else
    localparam int HEXM = 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] digest_tb;
    logic         dv;
    logic         byte_ready;
    logic         sel;

    logic         ack_a, busy_a, bv_a, last_a;
    logic [7:0]   bo_a;
    logic         ack_b, busy_b, bv_b, last_b;
    logic [7:0]   bo_b;

    logic         obs_ack, obs_busy, obs_bv, obs_last;
    logic [7:0]   obs_byte;

    int n_assert = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    int cyc_ctr  = 0;
    int t_first  = 0;
    int t_last   = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    digest_serializer #(.DIGEST_BITS(512)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .digest       (digest_tb),
        .digest_valid (dv & ~sel),
        .digest_ack   (ack_a),
        .busy         (busy_a),
        .byte_out     (bo_a),
        .byte_valid   (bv_a),
        .byte_ready   (byte_ready),
        .last         (last_a)
    );

    digest_serializer #(.DIGEST_BITS(256)) u_dut256 (
        .clk          (clk),
        .reset        (reset),
        .digest       (digest_tb[255:0]),
        .digest_valid (dv & sel),
        .digest_ack   (ack_b),
        .busy         (busy_b),
        .byte_out     (bo_b),
        .byte_valid   (bv_b),
        .byte_ready   (byte_ready),
        .last         (last_b)
    );

    assign obs_ack  = sel ? ack_b  : ack_a;
    assign obs_busy = sel ? busy_b : busy_a;
    assign obs_bv   = sel ? bv_b   : bv_a;
    assign obs_last = sel ? last_b : last_a;
    assign obs_byte = sel ? bo_b   : bo_a;

    always @(posedge clk) begin
        cyc_ctr <= cyc_ctr + 1;
        if (obs_ack && !reset) ack_cnt <= ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] nib2c(input logic [3:0] n);
        int v;
        v = int'(n);
        return (v < 10) ? 8'(48 + v) : 8'(97 + v - 10);
    endfunction

    // Expected transfer sequence: bytes MSB-first, each split into two
    // characters when hex output is enabled.
    task automatic build_exp(input logic [511:0] d, input int bits);
        logic [7:0] b;
        exp_q.delete();
        for (int i = 0; i < bits / 8; i++) begin
            b = d[(bits - 1 - 8 * i) -: 8];
            if (HEXM == 2) begin
                exp_q.push_back(nib2c(b[7:4]));
                exp_q.push_back(nib2c(b[3:0]));
            end else begin
                exp_q.push_back(b);
            end
        end
    endtask

    function automatic logic [511:0] rand_digest();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32 * i +: 32] = $urandom;
        return d;
    endfunction

    // Entered at a negedge with the selected DUT idle; returns at a negedge.
    task automatic stream(input logic [511:0] d, input int bits, input int rdy_pct,
                          input bit hold_dv, input int abort_after, output int cyc);
        int n;
        int idx;
        bit stalled;
        logic [7:0] prev_byte;
        logic prev_last;
        build_exp(d, bits);
        n = exp_q.size();
        digest_tb = d;
        dv = 1'b1;
        byte_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
        #1;
        chk("ack_on_capture", 32'(obs_ack), 1);
        chk("idle_busy", 32'(obs_busy), 0);
        @(posedge clk);
        @(negedge clk);
        if (!hold_dv) dv = 1'b0;
        idx = 0;
        cyc = 1;
        stalled = 1'b0;
        prev_byte = 8'h00;
        prev_last = 1'b0;
        t_first = cyc_ctr;
        while (idx < n && cyc < 4000) begin
            if (abort_after >= 0 && idx == abort_after) break;
            chk("byte_valid", 32'(obs_bv), 1);
            chk("busy", 32'(obs_busy), 1);
            chk("ack_quiet", 32'(obs_ack), 0);
            chk($sformatf("byte[%0d]", idx), 32'(obs_byte), 32'(exp_q[idx]));
            chk($sformatf("last[%0d]", idx), 32'(obs_last), 32'(idx == n - 1));
            if (stalled) begin
                chk("stall_byte_hold", 32'(obs_byte), 32'(prev_byte));
                chk("stall_last_hold", 32'(obs_last), 32'(prev_last));
            end
            prev_byte = obs_byte;
            prev_last = obs_last;
            byte_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
            @(posedge clk);
            if (byte_ready) idx++;
            stalled = !byte_ready;
            cyc++;
            @(negedge clk);
        end
        if (abort_after < 0) begin
            t_last = cyc_ctr;
            chk("transfer_count", 32'(idx), 32'(n));
            chk("done_valid", 32'(obs_bv), 0);
            chk("done_busy", 32'(obs_busy), 0);
            chk("done_last", 32'(obs_last), 0);
            chk("done_byte", 32'(obs_byte), 0);
        end
    endtask

    initial begin
        logic [511:0] d;
        int cyc;
        int a0;
        int tl;

        reset = 1'b1;
        dv = 1'b0;
        byte_ready = 1'b0;
        sel = 1'b0;
        digest_tb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_ack", 32'(obs_ack), 0);
            chk("rst_busy", 32'(obs_busy), 0);
            chk("rst_valid", 32'(obs_bv), 0);
            chk("rst_last", 32'(obs_last), 0);
            chk("rst_byte", 32'(obs_byte), 0);
        end
        sel = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // byte_ready toggling while idle must not start anything
        byte_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready_valid", 32'(obs_bv), 0);
            chk("idle_ready_byte", 32'(obs_byte), 0);
        end
        byte_ready = 1'b0;

        // Counting pattern, full throughput
        for (int i = 0; i < 64; i++) d[511 - 8 * i -: 8] = 8'(i);
        a0 = ack_cnt;
        stream(d, 512, 100, 1'b0, -1, cyc);
        chk("count_cycles", 32'(cyc), 32'(64 * HEXM + 1));
        chk("count_ack_once", 32'(ack_cnt - a0), 1);

        // Random digest, 50% ready
        stream(rand_digest(), 512, 50, 1'b0, -1, cyc);
        stream(rand_digest(), 512, 30, 1'b0, -1, cyc);

        // Top byte A7, rest zero
        d = '0;
        d[511 -: 8] = 8'hA7;
        stream(d, 512, 100, 1'b0, -1, cyc);
        chk("a7_cycles", 32'(cyc), 32'(64 * HEXM + 1));

        // digest_valid held high across two digests
        a0 = ack_cnt;
        stream(rand_digest(), 512, 100, 1'b1, -1, cyc);
        tl = t_last;
        chk("held_bubble_ack", 32'(obs_ack), 1);
        stream(rand_digest(), 512, 100, 1'b1, -1, cyc);
        dv = 1'b0;
        chk("held_restart_gap", 32'(t_first - tl), 1);
        chk("held_ack_twice", 32'(ack_cnt - a0), 2);
        @(negedge clk);
        chk("held_stays_idle", 32'(obs_bv), 0);

        // Reset after 10 transfers, then a fresh digest from byte 0
        stream(rand_digest(), 512, 100, 1'b0, 10, cyc);
        chk("pre_reset_busy", 32'(obs_busy), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 32'(obs_bv), 0);
        chk("midrst_busy", 32'(obs_busy), 0);
        chk("midrst_byte", 32'(obs_byte), 0);
        chk("midrst_last", 32'(obs_last), 0);
        reset = 1'b0;
        @(negedge clk);
        stream(rand_digest(), 512, 100, 1'b0, -1, cyc);

        // 256-bit instance
        sel = 1'b1;
        #1;
        stream(rand_digest(), 256, 100, 1'b0, -1, cyc);
        chk("w256_cycles", 32'(cyc), 32'(32 * HEXM + 1));
        stream(rand_digest(), 256, 50, 1'b0, -1, cyc);
        stream(rand_digest(), 256, 100, 1'b0, -1, cyc);
        sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
